// File: rtl/jacobian_pkg.sv
// Shared constants, fixed-point word type and FSM encoding for the
// jacobian multiplier bank.
package jacobian_pkg;

   localparam int MAX       = 6;
   localparam int WIDTH     = 27;
   localparam int FRAC_BITS = 16;
   localparam int MUL_LAT   = 3;
   localparam int IDX_W     = 6;

   typedef logic signed [WIDTH-1:0] fx_word_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/jacobian_fxmul.sv
// MUL_LAT-stage signed fixed-point multiplier (multiply, floor-shift, saturate)
// with a valid/tag pipeline running alongside the data.  Requires MUL_LAT >= 2.
module jacobian_fxmul #(
   parameter int WIDTH     = jacobian_pkg::WIDTH,
   parameter int FRAC_BITS = jacobian_pkg::FRAC_BITS,
   parameter int MUL_LAT   = jacobian_pkg::MUL_LAT,
   parameter int TAG_W     = jacobian_pkg::IDX_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_valid,
   input  logic [TAG_W-1:0] i_tag,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_valid,
   output logic [TAG_W-1:0] o_tag,
   output logic [WIDTH-1:0] o_p
);

   localparam int PW = 2 * WIDTH;
   localparam logic signed [PW-1:0] SAT_HI = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [PW-1:0] SAT_LO = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

   logic signed [PW-1:0] w_a_ext;
   logic signed [PW-1:0] w_b_ext;
   logic signed [PW-1:0] w_shift;
   logic        [WIDTH-1:0] w_sat;

   logic signed [PW-1:0]    r_prod;
   logic [MUL_LAT-1:0]      r_vld;
   logic [TAG_W-1:0]        r_tag  [MUL_LAT];
   logic [WIDTH-1:0]        r_word [1:MUL_LAT-1];

   assign w_a_ext = {{WIDTH{i_a[WIDTH-1]}}, i_a};
   assign w_b_ext = {{WIDTH{i_b[WIDTH-1]}}, i_b};

   // Arithmetic shift floors toward negative infinity.
   assign w_shift = r_prod >>> FRAC_BITS;

   always_comb begin
      w_sat = w_shift[WIDTH-1:0];
      if (w_shift > SAT_HI) begin
         w_sat = SAT_HI[WIDTH-1:0];
      end else if (w_shift < SAT_LO) begin
         w_sat = SAT_LO[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_vld  <= '0;
         r_prod <= '0;
         for (int s = 0; s < MUL_LAT; s++) r_tag[s] <= '0;
         for (int s = 1; s < MUL_LAT; s++) r_word[s] <= '0;
      end else begin
         r_vld    <= {r_vld[MUL_LAT-2:0], i_valid};
         r_tag[0] <= i_tag;
         for (int s = 1; s < MUL_LAT; s++) r_tag[s] <= r_tag[s-1];
         r_prod    <= w_a_ext * w_b_ext;
         r_word[1] <= w_sat;
         for (int s = 2; s < MUL_LAT; s++) r_word[s] <= r_word[s-1];
      end
   end

   assign o_valid = r_vld[MUL_LAT-1];
   assign o_tag   = r_tag[MUL_LAT-1];
   assign o_p     = r_word[MUL_LAT-1];

endmodule

// File: rtl/jacobian_mult_bank.sv
// Matrix element-wise multiplier bank: one shared pipelined multiplier is
// time-multiplexed over all MAX*MAX products; results are published atomically.
module jacobian_mult_bank #(
   parameter int MAX       = jacobian_pkg::MAX,
   parameter int WIDTH     = jacobian_pkg::WIDTH,
   parameter int FRAC_BITS = jacobian_pkg::FRAC_BITS,
   parameter int MUL_LAT   = jacobian_pkg::MUL_LAT
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 en,
   input  logic [MAX-1:0][MAX-1:0][WIDTH-1:0]   dataa,
   input  logic [MAX-1:0][MAX-1:0][WIDTH-1:0]   datab,
   output logic [MAX-1:0][MAX-1:0][WIDTH-1:0]   result,
   output logic                                 busy,
   output logic                                 done,
   output logic [1:0]                           dbg_state
);

   import jacobian_pkg::IDX_W;
   import jacobian_pkg::state_t;
   import jacobian_pkg::ST_IDLE;
   import jacobian_pkg::ST_ISSUE;
   import jacobian_pkg::ST_DRAIN;
   import jacobian_pkg::ST_DONE;

   localparam int N = MAX * MAX;
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N - 1);
   localparam logic [IDX_W-1:0] DRAIN_LAST = IDX_W'(MUL_LAT - 1);

   state_t r_state;
   state_t w_next;

   logic [IDX_W-1:0]        r_cnt;
   logic [N-1:0][WIDTH-1:0] r_a;
   logic [N-1:0][WIDTH-1:0] r_b;
   logic [N-1:0][WIDTH-1:0] r_shadow;
   logic [N-1:0][WIDTH-1:0] r_result;
   logic [N-1:0][WIDTH-1:0] w_merged;

   logic                    w_issue_vld;
   logic                    w_mul_vld;
   logic [IDX_W-1:0]        w_mul_tag;
   logic [WIDTH-1:0]        w_mul_p;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (en) w_next = ST_ISSUE;
         ST_ISSUE: if (r_cnt == LAST_IDX) w_next = ST_DRAIN;
         ST_DRAIN: if (r_cnt == DRAIN_LAST) w_next = ST_DONE;
         ST_DONE:  w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   // One counter serves as issue index in ISSUE and drain timer in DRAIN.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if ((r_state == ST_ISSUE || r_state == ST_DRAIN) && w_next == r_state) begin
         r_cnt <= r_cnt + 1'b1;
      end else begin
         r_cnt <= '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_a <= '0;
         r_b <= '0;
      end else if (r_state == ST_IDLE && en) begin
         r_a <= dataa;
         r_b <= datab;
      end
   end

   assign w_issue_vld = (r_state == ST_ISSUE);

   jacobian_fxmul #(
      .WIDTH     (WIDTH),
      .FRAC_BITS (FRAC_BITS),
      .MUL_LAT   (MUL_LAT),
      .TAG_W     (IDX_W)
   ) u_fxmul (
      .clk     (clk),
      .reset   (reset),
      .i_valid (w_issue_vld),
      .i_tag   (r_cnt),
      .i_a     (r_a[r_cnt]),
      .i_b     (r_b[r_cnt]),
      .o_valid (w_mul_vld),
      .o_tag   (w_mul_tag),
      .o_p     (w_mul_p)
   );

   // The last product retires on the same edge that enters DONE, so the
   // published matrix is taken from the shadow with that write already merged.
   always_comb begin
      w_merged = r_shadow;
      if (w_mul_vld) w_merged[w_mul_tag] = w_mul_p;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_shadow <= '0;
         r_result <= '0;
      end else begin
         r_shadow <= w_merged;
         if (r_state == ST_DRAIN && w_next == ST_DONE) r_result <= w_merged;
      end
   end

   assign result    = r_result;
   assign busy      = (r_state == ST_ISSUE) || (r_state == ST_DRAIN);
   assign done      = (r_state == ST_DONE);
   assign dbg_state = r_state;

endmodule

// File: tb/tb_jacobian_mult_bank.sv
// Directed bench for jacobian_mult_bank: latency, arithmetic, saturation,
// ordering, en-ignore, back-to-back jobs and mid-job reset.
module tb_jacobian_mult_bank;

   localparam int MAX   = 6;
   localparam int WIDTH = 27;

   typedef logic [MAX-1:0][MAX-1:0][WIDTH-1:0] mat_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   mat_t       dataa;
   mat_t       datab;
   mat_t       result;
   logic       busy;
   logic       done;
   logic [1:0] dbg_state;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   jacobian_mult_bank dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .dataa     (dataa),
      .datab     (datab),
      .result    (result),
      .busy      (busy),
      .done      (done),
      .dbg_state (dbg_state)
   );

   function automatic mat_t fill(input logic [WIDTH-1:0] v);
      mat_t m;
      for (int i = 0; i < MAX; i++)
         for (int j = 0; j < MAX; j++)
            m[i][j] = v;
      return m;
   endfunction

   task automatic report_mat(input string name, input mat_t exp);
      for (int i = 0; i < MAX; i++)
         for (int j = 0; j < MAX; j++)
            if (result[i][j] !== exp[i][j]) begin
               $display("FAIL %s [%0d][%0d] got=%h exp=%h", name, i, j, result[i][j], exp[i][j]);
               return;
            end
      $display("FAIL %s matrix differs", name);
   endtask

   // Accept a job, then count cycles (cycle 1 = first after the accepting edge) until done.
   task automatic run_job(input mat_t a, input mat_t b, output int lat, output bit busy_ok);
      @(negedge clk);
      dataa = a;
      datab = b;
      en    = 1'b1;
      @(negedge clk);
      en      = 1'b0;
      lat     = 1;
      busy_ok = 1'b1;
      while (done !== 1'b1 && lat < 200) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         @(negedge clk);
         lat++;
      end
      if (busy !== 1'b0) busy_ok = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      en    = 1'b0;
      dataa = '0;
      datab = '0;
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++;
      if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++;
      if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
      checks++;
      if (result !== '0) begin failures++; report_mat("reset_result", '0); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_identity;
      int lat;
      bit bok;
      run_job(fill(27'h0010000), fill(27'h0010000), lat, bok);
      checks++;
      if (lat !== 40) begin failures++; $display("FAIL ident_latency got=%0d exp=40", lat); end
      checks++;
      if (bok !== 1'b1) begin failures++; $display("FAIL ident_busy_profile got=%b exp=1", bok); end
      checks++;
      if (result !== fill(27'h0010000)) begin failures++; report_mat("ident_result", fill(27'h0010000)); end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || dbg_state !== 2'd0) begin
         failures++;
         $display("FAIL ident_after_done got done=%b busy=%b state=%0d exp 0/0/0", done, busy, dbg_state);
      end
   endtask

   task automatic test_signed;
      mat_t a, b, exp;
      int lat;
      bit bok;
      a = '0; b = '0; exp = '0;
      a[2][3] = 27'h7FE0000; b[2][3] = 27'h0018000; exp[2][3] = 27'h7FD0000;
      a[0][1] = 27'h7FFFFFF; b[0][1] = 27'h0008000; exp[0][1] = 27'h7FFFFFF;
      a[5][5] = 27'h0000001; b[5][5] = 27'h0008000; exp[5][5] = 27'h0000000;
      run_job(a, b, lat, bok);
      checks++;
      if (lat !== 40) begin failures++; $display("FAIL signed_latency got=%0d exp=40", lat); end
      checks++;
      if (result !== exp) begin failures++; report_mat("signed_result", exp); end
   endtask

   task automatic test_saturate;
      mat_t a, b, exp;
      int lat;
      bit bok;
      a = '0; b = '0; exp = '0;
      a[0][0] = 27'h3E80000; b[0][0] = 27'h0020000; exp[0][0] = 27'h3FFFFFF;
      run_job(a, b, lat, bok);
      checks++;
      if (lat !== 40) begin failures++; $display("FAIL sat_pos_latency got=%0d exp=40", lat); end
      checks++;
      if (result !== exp) begin failures++; report_mat("sat_pos_result", exp); end
      a[0][0] = 27'h4180000; exp[0][0] = 27'h4000000;
      run_job(a, b, lat, bok);
      checks++;
      if (lat !== 40) begin failures++; $display("FAIL sat_neg_latency got=%0d exp=40", lat); end
      checks++;
      if (result !== exp) begin failures++; report_mat("sat_neg_result", exp); end
   endtask

   task automatic test_ordering;
      mat_t a, exp;
      int lat;
      bit bok;
      for (int i = 0; i < MAX; i++)
         for (int j = 0; j < MAX; j++) begin
            a[i][j]   = WIDTH'((i * MAX + j + 1) << 16);
            exp[i][j] = WIDTH'((i * MAX + j + 1) << 16);
         end
      run_job(a, fill(27'h0010000), lat, bok);
      checks++;
      if (lat !== 40) begin failures++; $display("FAIL order_latency got=%0d exp=40", lat); end
      checks++;
      if (result !== exp) begin failures++; report_mat("order_result", exp); end
   endtask

   task automatic test_en_ignored;
      int cyc, ndone, first;
      @(negedge clk);
      dataa = fill(27'h0030000);
      datab = fill(27'h0008000);
      en    = 1'b1;
      @(negedge clk);
      en = 1'b0; cyc = 1; ndone = 0; first = 0;
      while (cyc < 60) begin
         if (cyc == 10) begin
            en    = 1'b1;
            dataa = '0;
            datab = fill(27'h0010000);
         end
         if (cyc == 11) en = 1'b0;
         if (done === 1'b1) begin
            ndone++;
            if (first == 0) first = cyc;
         end
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (ndone !== 1) begin failures++; $display("FAIL enign_done_count got=%0d exp=1", ndone); end
      checks++;
      if (first !== 40) begin failures++; $display("FAIL enign_latency got=%0d exp=40", first); end
      checks++;
      if (result !== fill(27'h0018000)) begin failures++; report_mat("enign_result_held", fill(27'h0018000)); end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL enign_idle_busy got=%b exp=0", busy); end
   endtask

   task automatic test_back_to_back;
      int cyc, ndone, d1, d2;
      @(negedge clk);
      dataa = fill(27'h0020000);
      datab = fill(27'h0020000);
      en    = 1'b1;
      @(negedge clk);
      cyc = 1; ndone = 0; d1 = 0; d2 = 0;
      while (cyc < 120) begin
         if (cyc == 5) dataa = fill(27'h0004000);
         if (done === 1'b1) begin
            ndone++;
            if (ndone == 1) begin
               d1 = cyc;
               checks++;
               if (result !== fill(27'h0040000)) begin failures++; report_mat("b2b_job1_result", fill(27'h0040000)); end
            end else begin
               d2 = cyc;
               checks++;
               if (result !== fill(27'h0008000)) begin failures++; report_mat("b2b_job2_result", fill(27'h0008000)); end
               break;
            end
         end
         @(negedge clk);
         cyc++;
      end
      en = 1'b0;
      checks++;
      if (d1 !== 40) begin failures++; $display("FAIL b2b_first_done got=%0d exp=40", d1); end
      checks++;
      if (d2 !== 81) begin failures++; $display("FAIL b2b_second_done got=%0d exp=81", d2); end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid_job;
      int lat;
      bit bok;
      @(negedge clk);
      dataa = fill(27'h0010000);
      datab = fill(27'h0030000);
      en    = 1'b1;
      @(negedge clk);
      en = 1'b0;
      repeat (19) @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL midrst_flags got busy=%b done=%b exp 0/0", busy, done);
      end
      checks++;
      if (result !== '0) begin failures++; report_mat("midrst_result", '0); end
      checks++;
      if (dbg_state !== 2'd0) begin failures++; $display("FAIL midrst_state got=%0d exp=0", dbg_state); end
      @(negedge clk);
      reset = 1'b0;
      repeat (45) begin
         @(negedge clk);
         if (done === 1'b1) begin
            failures++;
            $display("FAIL midrst_spurious_done got=1 exp=0");
         end
      end
      checks++;
      run_job(fill(27'h0028000), fill(27'h7FF8000), lat, bok);
      checks++;
      if (lat !== 40) begin failures++; $display("FAIL midrst_new_latency got=%0d exp=40", lat); end
      checks++;
      if (result !== fill(27'h7FEC000)) begin failures++; report_mat("midrst_new_result", fill(27'h7FEC000)); end
   endtask

   initial begin
      test_reset();
      test_identity();
      test_signed();
      test_saturate();
      test_ordering();
      test_en_ignored();
      test_back_to_back();
      test_reset_mid_job();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
